// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB over a req/ack unified memory port.
// Field outputs decode the IR combinationally; a stalled memory access faults after MEM_TIMEOUT cycles.
module multicycle_control #(
  parameter int ALU_OP_W    = 3,
  parameter int ALU_SRC_W   = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instruction,
  input  logic                 zero,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic                 reg_src,
  output logic [ALU_SRC_W-1:0] alu_src,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic [4:0]           addr_a,
  output logic [4:0]           addr_b,
  output logic [4:0]           addr_in,
  output logic [4:0]           shamt,
  output logic [15:0]          imm16,
  output logic [25:0]          addr26,
  output logic                 illegal_op,
  output logic                 fault,
  output logic [2:0]           state
);

  localparam logic [ALU_OP_W-1:0] OP_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] OP_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] OP_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] OP_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] OP_NOR = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] OP_SLT = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] OP_SLL = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] OP_SRL = ALU_OP_W'(7);

  localparam logic [ALU_SRC_W-1:0] SRC_REG_B = ALU_SRC_W'(0);
  localparam logic [ALU_SRC_W-1:0] SRC_SEXT  = ALU_SRC_W'(1);
  localparam logic [ALU_SRC_W-1:0] SRC_ZEXT  = ALU_SRC_W'(2);
  localparam logic [ALU_SRC_W-1:0] SRC_SHAMT = ALU_SRC_W'(3);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;

  logic [5:0]           opcode, funct;
  logic                 is_r, is_j, is_lw, is_sw, is_beq, is_bne, is_shift;
  logic                 dec_legal;
  logic [ALU_OP_W-1:0]  dec_op;
  logic [ALU_SRC_W-1:0] dec_src;
  logic                 waiting, tmo_hit;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign is_r   = (opcode == 6'h00);
  assign is_j   = (opcode == 6'h02);
  assign is_lw  = (opcode == 6'h23);
  assign is_sw  = (opcode == 6'h2B);
  assign is_beq = (opcode == 6'h04);
  assign is_bne = (opcode == 6'h05);

  assign addr_a  = instruction[25:21];
  assign addr_b  = instruction[20:16];
  assign addr_in = is_r ? instruction[15:11] : instruction[20:16];
  assign shamt   = is_shift ? instruction[10:6] : 5'd0;
  assign imm16   = instruction[15:0];
  assign addr26  = instruction[25:0];
  assign state   = state_q;

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = OP_ADD;
    dec_src   = SRC_REG_B;
    is_shift  = 1'b0;
    case (opcode)
      6'h00: begin
        dec_legal = 1'b1;
        case (funct)
          6'h20: dec_op = OP_ADD;
          6'h22: dec_op = OP_SUB;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h27: dec_op = OP_NOR;
          6'h2A: dec_op = OP_SLT;
          6'h00: begin dec_op = OP_SLL; dec_src = SRC_SHAMT; is_shift = 1'b1; end
          6'h02: begin dec_op = OP_SRL; dec_src = SRC_SHAMT; is_shift = 1'b1; end
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_legal = 1'b1; dec_op = OP_ADD; dec_src = SRC_SEXT; end
      6'h0C: begin dec_legal = 1'b1; dec_op = OP_AND; dec_src = SRC_ZEXT; end
      6'h0D: begin dec_legal = 1'b1; dec_op = OP_OR;  dec_src = SRC_ZEXT; end
      6'h23: begin dec_legal = 1'b1; dec_op = OP_ADD; dec_src = SRC_SEXT; end
      6'h2B: begin dec_legal = 1'b1; dec_op = OP_ADD; dec_src = SRC_SEXT; end
      // Branches compare rs-rt in the ALU; the sign-extended offset feeds the target adder.
      6'h04: begin dec_legal = 1'b1; dec_op = OP_SUB; dec_src = SRC_REG_B; end
      6'h05: begin dec_legal = 1'b1; dec_op = OP_SUB; dec_src = SRC_REG_B; end
      6'h02: dec_legal = 1'b1;
      default: dec_legal = 1'b0;
    endcase
  end

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ack;
  assign tmo_hit = (MEM_TIMEOUT != 0) && waiting &&
                   (cnt_q == TMO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
                else if (tmo_hit) state_d = S_FAULT;
      S_DECODE: state_d = (!dec_legal || is_j) ? S_FETCH : S_EXEC;
      S_EXEC:   if (is_beq || is_bne) state_d = S_FETCH;
                else if (is_lw || is_sw) state_d = S_MEM;
                else state_d = S_WB;
      S_MEM:    if (mem_ack) state_d = is_lw ? S_WB : S_FETCH;
                else if (tmo_hit) state_d = S_FAULT;
      S_WB:     state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
    // Counts consecutive unanswered request cycles within one state only.
    cnt_d = (waiting && (state_d == state_q)) ? cnt_q + TMO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    reg_write  = 1'b0;
    reg_src    = 1'b0;
    alu_op     = OP_ADD;
    alu_src    = SRC_REG_B;
    illegal_op = 1'b0;
    fault      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_DECODE: begin
          if (!dec_legal) illegal_op = 1'b1;
          else if (is_j) begin
            pc_write = 1'b1;
            pc_src   = 2'd2;
          end
        end
        S_EXEC: begin
          alu_op  = dec_op;
          alu_src = dec_src;
          if (is_beq) begin
            pc_write = zero;
            pc_src   = 2'd1;
          end else if (is_bne) begin
            pc_write = !zero;
            pc_src   = 2'd1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = is_sw;
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_src   = is_lw;
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle strobe/state vectors plus EXEC-stage decode sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset, zero, mem_ack;
  logic [31:0] instruction;
  logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, reg_src, illegal_op, fault;
  logic [1:0]  pc_src, alu_src;
  logic [2:0]  alu_op, state;
  logic [4:0]  addr_a, addr_b, addr_in, shamt;
  logic [15:0] imm16;
  logic [25:0] addr26;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instruction(instruction), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .reg_src(reg_src), .alu_src(alu_src), .alu_op(alu_op),
    .addr_a(addr_a), .addr_b(addr_b), .addr_in(addr_in), .shamt(shamt), .imm16(imm16),
    .addr26(addr26), .illegal_op(illegal_op), .fault(fault), .state(state)
  );

  localparam logic [31:0] ADDI = 32'h2010FEFE;  // addi $s0,$zero,0xFEFE
  localparam logic [31:0] LW   = 32'h8E080004;  // lw $t0,4($s0)
  localparam logic [31:0] SW   = 32'hAE080000;  // sw $t0,0($s0)
  localparam logic [31:0] BEQ  = 32'h1120FFFD;  // beq $t1,$zero,-3
  localparam logic [31:0] BNE  = 32'h1520FFFD;
  localparam logic [31:0] JMP  = 32'h08000100;
  localparam logic [31:0] BADO = 32'hFC000000;  // opcode 0x3F
  localparam logic [31:0] BADF = 32'h0000003F;  // R-type funct 0x3F
  localparam logic [31:0] ADD  = 32'h01095020;  // add $t2,$t0,$t1

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        z;
    logic        ack;
    logic [13:0] exp;
  } row_t;

  row_t rows[160];
  int   nrows = 0;
  int   n_pass = 0;
  int   n_total = 0;

  wire [13:0] act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                     reg_write, reg_src, illegal_op, fault};

  function automatic logic [13:0] e(input logic [2:0] st, input logic req, we, io, irw, pcw,
                                    input logic [1:0] pcs, input logic rw, rs, ill, flt);
    return {st, req, we, io, irw, pcw, pcs, rw, rs, ill, flt};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  task automatic add(input logic rst, input logic [31:0] ins, input logic z, input logic ack,
                     input logic [13:0] ex);
    rows[nrows] = '{rst, ins, z, ack, ex};
    nrows++;
  endtask

  task automatic fa(input logic [31:0] ins); add(0, ins, 0, 1, e(0,1,0,0,1,1,0,0,0,0,0)); endtask
  task automatic fw(input logic [31:0] ins); add(0, ins, 0, 0, e(0,1,0,0,0,0,0,0,0,0,0)); endtask
  task automatic dc(input logic [31:0] ins); add(0, ins, 0, 0, e(1,0,0,0,0,0,0,0,0,0,0)); endtask
  task automatic ex(input logic [31:0] ins); add(0, ins, 0, 0, e(2,0,0,0,0,0,0,0,0,0,0)); endtask

  task automatic exec_check(input string name, input logic [31:0] ins, input logic [2:0] op,
                            input logic [1:0] src, input logic [4:0] ain, input logic [4:0] sh);
    reset = 0; zero = 0; mem_ack = 1; instruction = ins;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, "_state"},  {29'd0, state}, 32'd2);
    chk({name, "_alu_op"}, {29'd0, alu_op}, {29'd0, op});
    chk({name, "_alu_src"}, {30'd0, alu_src}, {30'd0, src});
    chk({name, "_addr_in"}, {27'd0, addr_in}, {27'd0, ain});
    chk({name, "_shamt"}, {27'd0, shamt}, {27'd0, sh});
    for (int k = 0; k < 6 && state != 3'd0; k++) begin
      @(posedge clk); #1;
    end
    chk({name, "_back_to_fetch"}, {29'd0, state}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add(1, ADDI, 0, 1, e(0,0,0,0,0,0,0,0,0,0,0));
    // addi, zero-wait: 0,1,2,4 then FETCH
    fa(ADDI); dc(ADDI); ex(ADDI); add(0, ADDI, 0, 0, e(4,0,0,0,0,0,0,1,0,0,0));
    // lw with two FETCH waits and one MEM wait: 8 cycles
    fw(LW); fw(LW); fa(LW); dc(LW); ex(LW);
    add(0, LW, 0, 0, e(3,1,0,1,0,0,0,0,0,0,0));
    add(0, LW, 0, 1, e(3,1,0,1,0,0,0,0,0,0,0));
    add(0, LW, 0, 0, e(4,0,0,0,0,0,0,1,1,0,0));
    // branches on both zero values
    fa(BEQ); dc(BEQ); add(0, BEQ, 1, 0, e(2,0,0,0,0,1,1,0,0,0,0));
    fa(BEQ); dc(BEQ); add(0, BEQ, 0, 0, e(2,0,0,0,0,0,1,0,0,0,0));
    fa(BNE); dc(BNE); add(0, BNE, 1, 0, e(2,0,0,0,0,0,1,0,0,0,0));
    fa(BNE); dc(BNE); add(0, BNE, 0, 0, e(2,0,0,0,0,1,1,0,0,0,0));
    // jump resolves in DECODE
    fa(JMP); add(0, JMP, 0, 0, e(1,0,0,0,0,1,2,0,0,0,0));
    // illegal opcode and illegal funct pulse in DECODE, FETCH follows
    fa(BADO); add(0, BADO, 0, 0, e(1,0,0,0,0,0,0,0,0,1,0));
    fa(BADF); add(0, BADF, 0, 0, e(1,0,0,0,0,0,0,0,0,1,0));
    fa(ADD); dc(ADD); ex(ADD); add(0, ADD, 0, 0, e(4,0,0,0,0,0,0,1,0,0,0));
    // sw zero-wait
    fa(SW); dc(SW); ex(SW); add(0, SW, 0, 1, e(3,1,1,1,0,0,0,0,0,0,0));
    // reset during a stalled sw: quiet reset cycle, FETCH requests right after
    fa(SW); dc(SW); ex(SW); add(0, SW, 0, 0, e(3,1,1,1,0,0,0,0,0,0,0));
    add(1, SW, 0, 0, e(3,0,0,0,0,0,0,0,0,0,0));
    fw(SW);
    // sw stalled 15 cycles faults; late ack ignored; reset clears
    fa(SW); dc(SW); ex(SW);
    for (int k = 0; k < 15; k++) add(0, SW, 0, 0, e(3,1,1,1,0,0,0,0,0,0,0));
    add(0, SW, 0, 1, e(5,0,0,0,0,0,0,0,0,0,1));
    add(0, SW, 0, 1, e(5,0,0,0,0,0,0,0,0,0,1));
    add(1, SW, 0, 0, e(5,0,0,0,0,0,0,0,0,0,0));
    // 14 waits then ack must not fault
    for (int k = 0; k < 14; k++) fw(ADD);
    fa(ADD); dc(ADD); ex(ADD); add(0, ADD, 0, 0, e(4,0,0,0,0,0,0,1,0,0,0));

    reset = 1; zero = 0; mem_ack = 0; instruction = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < nrows; i++) begin
      reset = rows[i].rst; instruction = rows[i].ins; zero = rows[i].z; mem_ack = rows[i].ack;
      @(negedge clk);
      chk($sformatf("row%0d", i), {18'd0, act}, {18'd0, rows[i].exp});
      @(posedge clk); #1;
    end

    // EXEC-stage decode: alu_op (ADD0 SUB1 AND2 OR3 NOR4 SLT5 SLL6 SRL7), alu_src (REG_B0 SEXT1 ZEXT2 SHAMT3)
    exec_check("addi", ADDI,         3'd0, 2'd1, 5'd16, 5'd0);
    exec_check("ori",  32'h360800FF, 3'd3, 2'd2, 5'd8,  5'd0);
    exec_check("andi", 32'h320800FF, 3'd2, 2'd2, 5'd8,  5'd0);
    exec_check("sll",  32'h00095100, 3'd6, 2'd3, 5'd10, 5'd4);
    exec_check("srl",  32'h00095102, 3'd7, 2'd3, 5'd10, 5'd4);
    exec_check("add",  32'h01095160, 3'd0, 2'd0, 5'd10, 5'd0);
    exec_check("sub",  32'h01095022, 3'd1, 2'd0, 5'd10, 5'd0);
    exec_check("slt",  32'h0109502A, 3'd5, 2'd0, 5'd10, 5'd0);
    exec_check("nor",  32'h01095027, 3'd4, 2'd0, 5'd10, 5'd0);
    exec_check("lw",   LW,           3'd0, 2'd1, 5'd8,  5'd0);
    exec_check("sw",   SW,           3'd0, 2'd1, 5'd8,  5'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
